// File: rtl/uart_transceiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_transceiver
// Purpose  : Full-duplex 8N1 UART. Independent transmitter and receiver with
//            byte-wide valid/ready handshakes on the host side.
// Ports    : clk, reset           - system clock, synchronous active-high reset
//            data_in[7:0]         - byte to transmit
//            data_in_valid/ready  - TX handshake (ready high while TX idle)
//            data_out[7:0]        - last received byte
//            data_out_valid/ready - RX handshake (valid while byte unconsumed)
//            serial_in            - asynchronous RX line, idle high
//            serial_out           - TX line, idle high
// Revision : 1.0  initial release
// ============================================================================
module uart_transceiver #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  input  logic       serial_in,
  output logic       serial_out
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CW               = $clog2(SYMBOL_EDGE_TIME) + 1;
  // Terminal counts: a full bit period and half a bit period (start midpoint).
  localparam logic [CW-1:0] BIT_LAST  = CW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(SYMBOL_EDGE_TIME / 2 - 1);

  // --------------------------------------------------------------------------
  // Transmitter
  // --------------------------------------------------------------------------
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  tx_state_t     tx_state, tx_state_next;
  logic [9:0]    tx_shift;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bits;
  logic          tx_load;
  logic          tx_tick;

  always_ff @(posedge clk) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state;
    tx_load       = 1'b0;
    tx_tick       = (tx_cnt == BIT_LAST);
    case (tx_state)
      TX_IDLE: begin
        if (data_in_valid) begin
          tx_load       = 1'b1;
          tx_state_next = TX_SEND;
        end
      end
      TX_SEND: begin
        // Leave after the tenth (stop) bit period has fully elapsed.
        if (tx_tick && tx_bits == 4'd9) tx_state_next = TX_IDLE;
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift <= '1;
      tx_cnt   <= '0;
      tx_bits  <= '0;
    end else if (tx_load) begin
      tx_shift <= {1'b1, data_in, 1'b0};
      tx_cnt   <= '0;
      tx_bits  <= '0;
    end else if (tx_state == TX_SEND) begin
      if (tx_tick) begin
        tx_cnt   <= '0;
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_bits  <= tx_bits + 4'd1;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // Decoded from the state register so a reset forces the line high on the
  // very next edge, even mid-frame.
  assign data_in_ready = (tx_state == TX_IDLE);
  assign serial_out    = (tx_state == TX_SEND) ? tx_shift[0] : 1'b1;

  // --------------------------------------------------------------------------
  // Receiver
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     rx_state, rx_state_next;
  logic          rx_sync1, rx_sync2, rx_prev;
  logic [7:0]    rx_shift;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bits;
  logic          has_byte;
  logic          rx_fall;
  logic          rx_tick;
  logic          rx_half;
  logic          byte_done;

  // Two-flop synchronizer, plus one more flop to detect the falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= serial_in;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync2;

  always_ff @(posedge clk) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state;
    rx_tick       = (rx_cnt == BIT_LAST);
    rx_half       = (rx_cnt == HALF_LAST);
    byte_done     = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_state_next = RX_START;
      // Line back high at the start-bit midpoint means it was a glitch.
      RX_START: if (rx_half) rx_state_next = rx_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bits == 3'd7) rx_state_next = RX_STOP;
      RX_STOP: begin
        if (rx_tick) begin
          rx_state_next = RX_IDLE;
          byte_done     = rx_sync2;  // a low stop bit drops the byte
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      data_out <= '0;
      has_byte <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt  <= '0;
          rx_bits <= '0;
        end
        RX_START: rx_cnt <= rx_half ? '0 : rx_cnt + 1'b1;
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync2, rx_shift[7:1]};
            rx_bits  <= rx_bits + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
        default: rx_cnt <= '0;
      endcase

      // A completing byte overrides a simultaneous consume (new byte wins).
      if (byte_done) begin
        data_out <= rx_shift;
        has_byte <= 1'b1;
      end else if (data_out_valid && data_out_ready) begin
        has_byte <= 1'b0;
      end
    end
  end

  assign data_out_valid = has_byte && (rx_state == RX_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_transceiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_transceiver
// Purpose  : Self-checking bench for uart_transceiver: table of TX frames,
//            loopback streams, RX hold/overrun, glitch/framing, mid-frame
//            reset and randomized traffic against a byte-queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_transceiver;

  localparam int CLOCK_FREQ = 100_000_000;
  localparam int BAUD_RATE  = 4_000_000;
  localparam int SET        = CLOCK_FREQ / BAUD_RATE;  // 25 cycles per bit

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready = 1'b0;
  logic       serial_in;
  logic       serial_out;
  logic       loopback = 1'b0;
  logic       drv_rx = 1'b1;

  assign serial_in = loopback ? serial_out : drv_rx;

  always #5 clk = ~clk;

  uart_transceiver #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .serial_in     (serial_in),
    .serial_out    (serial_out)
  );

  int tests = 0;
  int fails = 0;

  // Every byte the DUT hands over (valid & ready) is logged here.
  logic [7:0] rx_q[$];

  always @(negedge clk)
    if (!reset && data_out_valid && data_out_ready) rx_q.push_back(data_out);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_q(input string name, input logic [7:0] exp_q[$]);
    check({name, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), {24'h0, rx_q[i]}, {24'h0, exp_q[i]});
  endtask

  // All tasks start and end #1 after a rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tx(input logic [7:0] d);
    int n = 0;
    while (!data_in_ready && n < 20 * SET) begin
      next_cycle();
      n++;
    end
    if (!data_in_ready) check("tx_ready_timeout", 32'(data_in_ready), 32'd1);
    data_in       = d;
    data_in_valid = 1'b1;
    next_cycle();                 // handshake edge
    data_in_valid = 1'b0;
    data_in       = 8'($urandom); // must be ignored
  endtask

  // Sends a byte and samples serial_out at each bit midpoint; also counts
  // cycles where data_in_ready disagrees with "low for exactly 10 bits".
  task automatic send_tx(input logic [7:0] d, output logic [9:0] frame, output int ready_bad);
    frame     = '0;
    ready_bad = 0;
    start_tx(d);
    for (int c = 0; c <= 10 * SET; c++) begin
      if (c != 0) next_cycle();
      if (c < 10 * SET && (c % SET) == SET / 2) frame[c / SET] = serial_out;
      if (data_in_ready !== (c == 10 * SET)) ready_bad++;
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drv_rx = f[i];
      repeat (SET) next_cycle();
    end
    drv_rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // bit i = line value during bit period i
    logic [7:0] exp_rx;
  } tx_vec_t;

  tx_vec_t    vecs[5];
  logic [9:0] frame;
  int         rbad;
  logic [7:0] exp_q[$];
  logic [7:0] rnd;
  logic       stop_ok;

  initial begin
    vecs[0] = '{8'h3E, 10'b1_0011_1110_0, 8'h3E};
    vecs[1] = '{8'h00, 10'b1_0000_0000_0, 8'h00};
    vecs[2] = '{8'hFF, 10'b1_1111_1111_0, 8'hFF};
    vecs[3] = '{8'h55, 10'b1_0101_0101_0, 8'h55};
    vecs[4] = '{8'hA5, 10'b1_1010_0101_0, 8'hA5};

    // ---------------- reset state ----------------
    repeat (10) next_cycle();
    check("rst_serial_out", 32'(serial_out), 32'd1);
    check("rst_in_ready", 32'(data_in_ready), 32'd1);
    check("rst_out_valid", 32'(data_out_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'h00);
    reset = 1'b0;
    next_cycle();

    // ---------------- table: TX frames, looped back into RX ----------------
    loopback       = 1'b1;
    data_out_ready = 1'b1;
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      send_tx(vecs[i].data, frame, rbad);
      check($sformatf("tx_frame_%0h", vecs[i].data), 32'(frame), 32'(vecs[i].frame));
      check($sformatf("tx_ready_window_%0h", vecs[i].data), rbad, 0);
      exp_q.push_back(vecs[i].exp_rx);
    end
    repeat (2) next_cycle();
    compare_q("table_loopback", exp_q);

    // ---------------- back-to-back loopback string ----------------
    rx_q.delete();
    exp_q = '{8'h68, 8'h65, 8'h6C, 8'h70, 8'h0D, 8'h0A};
    foreach (exp_q[i]) send_tx(exp_q[i], frame, rbad);
    repeat (2) next_cycle();
    compare_q("b2b_loopback", exp_q);

    // ---------------- randomized loopback with random gaps ----------------
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      rnd = 8'($urandom);
      send_tx(rnd, frame, rbad);
      check($sformatf("rnd_tx_frame%0d", i), 32'(frame), 32'({1'b1, rnd, 1'b0}));
      exp_q.push_back(rnd);
      repeat ($urandom_range(0, 3)) next_cycle();
    end
    repeat (2) next_cycle();
    compare_q("rnd_loopback", exp_q);

    // ---------------- RX hold and overrun ----------------
    loopback       = 1'b0;
    data_out_ready = 1'b0;
    rx_q.delete();
    drive_frame(8'hA5, 1'b1);
    repeat (SET) next_cycle();
    check("hold_valid", 32'(data_out_valid), 32'd1);
    check("hold_data", 32'(data_out), 32'hA5);
    fork
      drive_frame(8'h5A, 1'b1);
      begin
        repeat (3 * SET) next_cycle();
        check("valid_low_during_rx", 32'(data_out_valid), 32'd0);
      end
    join
    repeat (SET) next_cycle();
    check("overrun_valid", 32'(data_out_valid), 32'd1);
    check("overrun_data", 32'(data_out), 32'h5A);
    data_out_ready = 1'b1;
    next_cycle();
    data_out_ready = 1'b0;
    check("consume_valid_drop", 32'(data_out_valid), 32'd0);
    exp_q = '{8'h5A};
    compare_q("consume_once", exp_q);

    // ---------------- glitch and framing error ----------------
    data_out_ready = 1'b1;
    rx_q.delete();
    drv_rx = 1'b0;
    repeat (SET / 4) next_cycle();
    drv_rx = 1'b1;
    repeat (12 * SET) next_cycle();
    check("glitch_no_valid", 32'(data_out_valid), 32'd0);
    drive_frame(8'h77, 1'b0);
    repeat (SET) next_cycle();
    check("framing_no_valid", 32'(data_out_valid), 32'd0);
    drive_frame(8'h3C, 1'b1);
    repeat (SET) next_cycle();
    exp_q = '{8'h3C};
    compare_q("glitch_framing", exp_q);

    // ---------------- randomized RX frames with random stop errors ----------------
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      rnd     = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      drive_frame(rnd, stop_ok);
      if (stop_ok) exp_q.push_back(rnd);
      repeat ($urandom_range(SET, 3 * SET)) next_cycle();
    end
    compare_q("rnd_rx", exp_q);

    // ---------------- mid-frame reset ----------------
    loopback = 1'b1;
    rx_q.delete();
    start_tx(8'h2F);                        // data bit 4 is 0
    repeat (5 * SET + SET / 2) next_cycle();
    check("tx_bit4_before_reset", 32'(serial_out), 32'd0);
    reset = 1'b1;
    next_cycle();
    check("reset_serial_out", 32'(serial_out), 32'd1);
    check("reset_in_ready", 32'(data_in_ready), 32'd1);
    check("reset_data_out", 32'(data_out), 32'h00);
    repeat (3) next_cycle();
    reset = 1'b0;
    next_cycle();
    send_tx(8'h01, frame, rbad);
    check("post_reset_frame", 32'(frame), 32'(10'b1_0000_0001_0));
    check("post_reset_ready_window", rbad, 0);
    repeat (2) next_cycle();
    exp_q = '{8'h01};
    compare_q("post_reset_rx", exp_q);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
